// File: rtl/alu_flags_writeback.sv
// Writeback stage after the add/subtract unit: a result FIFO toward the register file,
// plus the architectural NZCV register whose carry feeds back to the adder for ADCS.
module alu_flags_writeback #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_s,
    input  logic                     in_n,
    input  logic                     in_z,
    input  logic                     in_c,
    input  logic                     in_v,
    input  logic                     in_setflags,
    input  logic [TAGW-1:0]          in_rd,
    input  logic                     flags_wr_en,
    input  logic [3:0]               flags_wr_data,
    output logic [3:0]               apsr,
    output logic                     carry_fb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAGW-1:0]          out_rd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [TAGW-1:0]  rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            acc;
    logic            pop;
    logic [CW-1:0]   count_nxt;

    // Handshakes and next occupancy
    always_comb begin
        acc       = in_valid & in_ready;
        pop       = out_valid & out_ready;
        count_nxt = count;
        case ({acc, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy, and ready/valid registered from next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            if (acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count     <= count_nxt;
            in_ready  <= (count_nxt != CW'(DEPTH));
            out_valid <= (count_nxt != '0);
        end
    end

    // Storage is cleared on reset so the head reads zero when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (acc) begin
            mem[wr_ptr] <= '{rd: in_rd, data: in_s};
        end
    end

    assign out_data = mem[rd_ptr].data;
    assign out_rd   = mem[rd_ptr].rd;

    // Flags commit at acceptance; a direct write overrides a same-cycle flag-setting op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apsr <= 4'b0000;
        end else if (flags_wr_en) begin
            apsr <= flags_wr_data;
        end else if (acc && in_setflags) begin
            apsr <= {in_n, in_z, in_c, in_v};
        end
    end

    assign carry_fb = apsr[1];

endmodule

// File: tb/tb_alu_flags_writeback.sv
// Scoreboard bench for alu_flags_writeback: accepted results are queued and a
// monitor compares each popped head; flag/occupancy behaviour is checked directly.
module tb_alu_flags_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_n, in_z, in_c, in_v;
    logic        in_setflags;
    logic [3:0]  in_rd;
    logic        flags_wr_en;
    logic [3:0]  flags_wr_data;
    logic [3:0]  apsr;
    logic        carry_fb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_rd;
    logic [1:0]  count;

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;

    alu_flags_writeback #(.WIDTH(32), .DEPTH(2), .TAGW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
        .in_n(in_n), .in_z(in_z), .in_c(in_c), .in_v(in_v),
        .in_setflags(in_setflags), .in_rd(in_rd),
        .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
        .apsr(apsr), .carry_fb(carry_fb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every pop is compared against the oldest accepted result
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got data 0x%08h rd %0d with nothing outstanding",
                         out_data, out_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_data !== e.data || out_rd !== e.rd) begin
                    failures++;
                    $display("FAIL pop_order: got data 0x%08h rd %0d expected data 0x%08h rd %0d",
                             out_data, out_rd, e.data, e.rd);
                end
            end
        end
    end

    // Present one result and hold it until accepted; returns #1 after the accepting edge
    task automatic send(input logic [31:0] s, input logic [3:0] rd, input logic [3:0] nzcv,
                        input logic sf);
        bit done;
        done        = 1'b0;
        in_valid    = 1'b1;
        in_s        = s;
        in_rd       = rd;
        {in_n, in_z, in_c, in_v} = nzcv;
        in_setflags = sf;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{rd: rd, data: s});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid    = 1'b0;
        in_setflags = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: result 0x%08h never accepted, required acceptance", s);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_s          = '0;
        {in_n, in_z, in_c, in_v} = 4'b0000;
        in_setflags   = 1'b0;
        in_rd         = '0;
        flags_wr_en   = 1'b0;
        flags_wr_data = '0;
        out_ready     = 1'b0;

        // Reset values
        #12;
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_out_valid",32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready),  32'd1);
        chk("rst_apsr",     32'(apsr),      32'd0);
        chk("rst_carry_fb", 32'(carry_fb),  32'd0);
        chk("rst_out_data", out_data,       32'd0);
        chk("rst_out_rd",   32'(out_rd),    32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // SUBS: flags N0 Z0 C1 V1 commit on the accepting edge
        send(32'h0000_0001, 4'd1, 4'b0011, 1'b1);
        chk("subs_apsr",      32'(apsr),      32'h3);
        chk("subs_carry_fb",  32'(carry_fb),  32'd1);
        chk("subs_out_valid", 32'(out_valid), 32'd1);
        chk("subs_out_data",  out_data,       32'h0000_0001);
        out_ready = 1'b1;
        idle(2);

        // Plain ADD leaves flags alone
        out_ready = 1'b0;
        send(32'hFFFF_FFFF, 4'd2, 4'b1000, 1'b0);
        chk("add_apsr",     32'(apsr), 32'h3);
        chk("add_out_data", out_data,  32'hFFFF_FFFF);
        out_ready = 1'b1;
        idle(2);
        chk("add_drained", 32'(count), 32'd0);

        // Fill to DEPTH under backpressure, third result held, then drain in order
        out_ready = 1'b0;
        send(32'hA000_0001, 4'd3, 4'b0000, 1'b0);
        send(32'hA000_0002, 4'd4, 4'b0000, 1'b0);
        chk("full_count",    32'(count),    32'd2);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        fork
            send(32'hA000_0003, 4'd5, 4'b0000, 1'b0);
            begin
                idle(3);
                chk("held_count", 32'(count), 32'd2);
                chk("held_data",  out_data,   32'hA000_0001);
                out_ready = 1'b1;
            end
        join
        idle(3);
        chk("drain_count", 32'(count), 32'd0);

        // Five writes so far: both pointers sit at 1, so the next push wraps to 0
        out_ready = 1'b0;
        send(32'hB000_0001, 4'd6, 4'b0000, 1'b0);
        chk("wrap_count1", 32'(count), 32'd1);
        out_ready = 1'b1;
        send(32'hB000_0002, 4'd7, 4'b0000, 1'b0);
        chk("simul_count_a", 32'(count), 32'd1);
        send(32'hB000_0003, 4'd8, 4'b0000, 1'b0);
        chk("simul_count_b", 32'(count), 32'd1);
        idle(2);
        chk("simul_drained", 32'(count), 32'd0);

        // Direct flag write beats a same-cycle SUBS; data still enqueued
        out_ready     = 1'b0;
        flags_wr_en   = 1'b1;
        flags_wr_data = 4'b1000;
        send(32'hC000_0001, 4'd9, 4'b0110, 1'b1);
        flags_wr_en   = 1'b0;
        chk("coll_apsr",     32'(apsr),    32'h8);
        chk("coll_count",    32'(count),   32'd1);
        chk("coll_out_data", out_data,     32'hC000_0001);
        chk("coll_out_rd",   32'(out_rd),  32'd9);
        send(32'hC000_0002, 4'd10, 4'b0000, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd2);

        // Asynchronous reset between edges discards buffered results
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_count",     32'(count),     32'd0);
        chk("mrst_apsr",      32'(apsr),      32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        q.delete();
        #3 rst_n = 1'b1;
        idle(1);

        // Stage works again after reset and carry feeds back
        out_ready = 1'b1;
        send(32'hD000_0001, 4'd11, 4'b0010, 1'b1);
        chk("post_carry_fb", 32'(carry_fb), 32'd1);
        idle(3);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_count",       32'(count),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
